// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 8-bit core
package cpu_pkg;

    localparam int PC_W = 10;

    typedef enum logic [1:0] {
        EQ  = 2'd0,
        NE  = 2'd1,
        LTU = 2'd2,
        ALW = 2'd3
    } br_cond_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } pc_state_t;

    // Branch targets emitted by the assembler; index 0 is first in the list
    localparam logic [PC_W-1:0] BR_TARGETS [0:31] = '{
        10'h000, 10'h010, 10'h040, 10'h120, 10'h080, 10'h0A0, 10'h0C0, 10'h0E0,
        10'h100, 10'h140, 10'h160, 10'h180, 10'h1A0, 10'h1C0, 10'h1E0, 10'h200,
        10'h220, 10'h240, 10'h260, 10'h280, 10'h2A0, 10'h2C0, 10'h2E0, 10'h300,
        10'h320, 10'h340, 10'h360, 10'h380, 10'h3A0, 10'h3C0, 10'h3E0, 10'h3FE
    };

endpackage

// File: rtl/branch_target_lut.sv
// rtl/branch_target_lut.sv - combinational branch index to target address ROM
module branch_target_lut #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 5
) (
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic [PC_W-1:0]      o_target
);

    // Pure table read; the table lives in the package so the bench sees the same values
    always_comb begin
        o_target = PC_W'(cpu_pkg::BR_TARGETS[i_idx]);
    end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC sequencing, branch resolution, start/halt control
module branch_pc_unit #(
    parameter int              PC_W       = 10,
    parameter int              LUT_IDX_W  = 5,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Stall,
    input  logic                 Branch,
    input  logic                 Halt,
    input  logic [1:0]           BrCond,
    input  logic [7:0]           BrOpA,
    input  logic [7:0]           BrOpB,
    input  logic [LUT_IDX_W-1:0] BrTgtIdx,
    output logic [PC_W-1:0]      PC,
    output logic                 Flush,
    output logic                 Taken,
    output logic                 Done
);

    import cpu_pkg::*;

    pc_state_t       r_state;
    pc_state_t       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_cond;
    logic [PC_W-1:0] w_target;

    branch_target_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_lut (
        .i_idx    (BrTgtIdx),
        .o_target (w_target)
    );

    // Branch condition on the two 8-bit operands (LTU is unsigned)
    always_comb begin
        w_cond = 1'b0;
        case (br_cond_t'(BrCond))
            EQ:      w_cond = (BrOpA == BrOpB);
            NE:      w_cond = (BrOpA != BrOpB);
            LTU:     w_cond = (BrOpA < BrOpB);
            ALW:     w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign Taken = Branch & (r_state == RUN) & ~Stall & w_cond;
    assign Flush = (r_state == FLUSH);
    assign PC    = r_pc;
    assign Done  = r_done;

    // Next state, PC and Done; Start overrides Stall only from IDLE/HALTED
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_done_nxt  = r_done;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_ADDR;
                end
            end
            RUN: begin
                if (Stall) begin
                    w_state_nxt = RUN;
                end else if (Halt) begin
                    w_state_nxt = HALTED;
                    w_done_nxt  = 1'b1;
                end else if (Taken) begin
                    w_state_nxt = FLUSH;
                    w_pc_nxt    = w_target;
                end else begin
                    w_pc_nxt    = r_pc + PC_W'(1);
                end
            end
            FLUSH: begin
                // Branch/Halt here belong to the squashed instruction
                if (!Stall) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = r_pc + PC_W'(1);
                end
            end
            HALTED: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_ADDR;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, PC and Done registers with asynchronous clear
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage for the 8-bit core. Consumes the branch operand produced by the branch operand mux (`BrOpA`, the R0/ReadReg1 selection) plus a second register operand. It evaluates the branch condition, looks up the target address, and drives the 10-bit fetch PC. It also sequences program start, halt and the one-cycle fetch bubble after a taken branch.

## Interface
Parameters:
- `PC_W`, default 10: program counter width.
- `LUT_IDX_W`, default 5: branch-target LUT index width (32 entries).
- `START_ADDR`, default 10'd0: PC loaded on `Start`.

Ports:
- `CLK`, input, 1: the single clock; all state changes on its rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: launch program; honoured only in IDLE or HALTED.
- `Stall`, input, 1: freeze PC and state this cycle.
- `Branch`, input, 1: decode holds a branch instruction.
- `Halt`, input, 1: decode holds the halt instruction.
- `BrCond`, input, 2: branch condition, one of EQ=0, NE=1, LTU=2, ALW=3.
- `BrOpA`, input, 8: first operand, from the branch operand mux.
- `BrOpB`, input, 8: second operand, ReadReg2.
- `BrTgtIdx`, input, `LUT_IDX_W`: target LUT index.
- `PC`, output, `PC_W`: fetch address.
- `Flush`, output, 1: instruction currently in decode is squashed.
- `Taken`, output, 1: combinational; the branch in decode is taken this cycle.
- `Done`, output, 1: program halted.

## Operation
- The FSM has four states: IDLE, RUN, FLUSH, HALTED.
- **Reset.** Asserting `Reset_n` low forces IDLE, `PC`=0, `Flush`=0, `Done`=0 immediately, at any time, including mid-branch or mid-FLUSH.
- **IDLE.**
  - `Start`=1: next state RUN, `PC`←`START_ADDR`.
  - Otherwise hold. `Branch` and `Halt` are ignored.
- **RUN.** Priority order: `Stall` > `Halt` > taken branch > increment.
  - `Halt`: next state HALTED, PC held.
  - `Taken`: `PC`←LUT[`BrTgtIdx`], next state FLUSH.
  - Otherwise: `PC`←`PC`+1.
- **FLUSH.**
  - `Flush`=1 for exactly this state.
  - `PC`←`PC`+1, next state RUN.
  - `Branch` and `Halt` are ignored, because they belong to the squashed instruction.
- **HALTED.**
  - `Done`=1 and PC held.
  - `Start`: `PC`←`START_ADDR`, `Done`→0, next state RUN.
- **Taken rule.** `Taken` = `Branch` & (state==RUN) & !`Stall` & cond, where cond is:
  - EQ: A==B
  - NE: A!=B
  - LTU: A<B, unsigned 8-bit
  - ALW: 1
- **Arithmetic.** PC increment is modulo 2^`PC_W`, so 1023+1 wraps to 0 with no flag. LUT entries are `PC_W` bits wide.
- **Stall.** `Stall` in any state except IDLE/HALTED-with-`Start` holds state and PC. `Stall` in FLUSH keeps `Flush`=1 for the extra cycle.
- **Start.** `Start` in RUN or FLUSH is ignored.

## Timing
- `PC` and `Done` are registered. `Flush` is decoded from the registered state. `Taken` is combinational from inputs plus state.
- Branch resolution latency: a taken branch sampled at edge N makes `PC`=target after edge N, and `Flush`=1 during the cycle after edge N.
- Taken-branch penalty is 1 bubble. A not-taken branch has zero penalty.
- `Start` → first `PC` valid: 1 cycle.
- `Halt` → `Done`=1: 1 cycle.
- Reset values: `PC`=0, `Flush`=0, `Done`=0, state IDLE. `Taken`=0 while in reset.
- `Branch` and `Halt` asserted together in RUN: halt wins, no redirect.

## Structure
- Shared package `cpu_pkg` holds:
  - `br_cond_t` enum (EQ, NE, LTU, ALW)
  - `pc_state_t` enum (IDLE, RUN, FLUSH, HALTED)
  - `PC_W`
  - constant array `BR_TARGETS[32]` of `PC_W`-bit targets
- Sub-module `branch_target_lut` (combinational index→target ROM). It is read by `branch_pc_unit` and shared with the assembler-matching testbench.
- Condition evaluation and FSM stay inline.

## Test plan
- Reset then `Start`: `PC`=0, then increments 0,1,2,3 on successive cycles. Check that `Done`=0 and `Flush`=0 throughout.
- BEQ with `BrOpA`=8'h5A, `BrOpB`=8'h5A, `BrTgtIdx`=3 (LUT[3]=10'h120) at PC=7:
  - next cycle `PC`=10'h120 with `Flush`=1;
  - the cycle after, `PC`=10'h121 with `Flush`=0.
- BLTU with `BrOpA`=8'h80, `BrOpB`=8'h7F: not taken, `PC` increments, no `Flush`. Swapping the operands makes it taken.
- PC at 10'h3FF with no branch: next `PC`=0.
- `Branch`(ALW) and `Halt` together at PC=9:
  - state HALTED, `Done`=1, PC stays 9;
  - then `Start` gives `PC`=0, `Done`=0.
- `Reset_n` dropped during FLUSH: `Flush`, `PC` and `Done` go to 0 asynchronously before the next edge. After release the unit is IDLE and ignores `Branch`.
